// File: rtl/btn_debounce_pulse_pkg.sv
// btn_debounce_pulse_pkg: debounce state encodings shared by button and key blocks
package btn_debounce_pulse_pkg;
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_HELD        = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } btn_state_t;
endpackage

// File: rtl/btn_debounce_pulse_sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous pin, reset to a chosen idle level
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            o_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end
endmodule

// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: debounces a push-button into a level plus press/release/long-press flags
// Long-press flag enabled by defining BTN_DEBOUNCE_LONGPRESS_EN.
module btn_debounce_pulse
    import btn_debounce_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int LONG_CYCLES     = 24000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] C_TERM = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_param
        $error("btn_debounce_pulse: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
    end

    logic       w_sync;
    logic       w_sample;
    logic       w_accept_press;
    btn_state_t r_state;
    logic [CW-1:0] r_cnt;

    sync_2ff #(.RST_VAL(ACTIVE_LOW)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_btn),
        .o_q   (w_sync)
    );

    assign w_sample       = w_sync ^ ACTIVE_LOW;
    assign w_accept_press = (r_state == ST_PRESS_CHK) && w_sample && (r_cnt == C_TERM);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            o_level         <= 1'b0;
            o_press_pulse   <= 1'b0;
            o_release_pulse <= 1'b0;
        end else begin
            o_press_pulse   <= 1'b0;
            o_release_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_sample) begin
                    r_state <= ST_PRESS_CHK;
                    r_cnt   <= '0;
                end
                ST_PRESS_CHK: if (!w_sample) begin
                    r_state <= ST_IDLE;
                end else if (r_cnt == C_TERM) begin
                    r_state       <= ST_HELD;
                    o_press_pulse <= 1'b1;
                    o_level       <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_HELD: if (!w_sample) begin
                    r_state <= ST_RELEASE_CHK;
                    r_cnt   <= '0;
                end
                ST_RELEASE_CHK: if (w_sample) begin
                    r_state <= ST_HELD;
                end else if (r_cnt == C_TERM) begin
                    r_state         <= ST_IDLE;
                    o_release_pulse <= 1'b1;
                    o_level         <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            endcase
        end
    end

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    localparam int LW = $clog2(LONG_CYCLES);
    localparam logic [LW-1:0] L_TERM = LW'(LONG_CYCLES - 1);
    logic [LW-1:0] r_lcnt;

    // Saturating at L_TERM keeps the flag to one per accepted press; RELEASE_CHK holds the count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lcnt       <= '0;
            o_long_pulse <= 1'b0;
        end else begin
            o_long_pulse <= 1'b0;
            if (w_accept_press) begin
                r_lcnt <= '0;
            end else if (r_state == ST_HELD && r_lcnt != L_TERM) begin
                r_lcnt       <= r_lcnt + 1'b1;
                o_long_pulse <= (r_lcnt == L_TERM - 1'b1);
            end
        end
    end
`else
    assign o_long_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb_btn_debounce_pulse: directed checks of debounce latency, glitch/bounce rejection, reset and long press
module tb_btn_debounce_pulse;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b1;
    logic level, press, release_p, long_p;
    int   n_chk = 0;
    int   n_fail = 0;

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    localparam int LE = 42;
`else
    localparam int LE = 0;
`endif

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES (8),
        .ACTIVE_LOW      (1'b1),
        .LONG_CYCLES     (32)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_btn           (btn),
        .o_level         (level),
        .o_press_pulse   (press),
        .o_release_pulse (release_p),
        .o_long_pulse    (long_p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic watch(input string name, input int n, input int pe, input int re,
                         input int le, input logic lv0);
        int ev;
        ev = pe | re;
        for (int k = 1; k <= n; k++) begin
            tick();
            chk($sformatf("%s press@%0d", name, k), press, k == pe);
            chk($sformatf("%s release@%0d", name, k), release_p, k == re);
            chk($sformatf("%s long@%0d", name, k), long_p, k == le);
            chk($sformatf("%s level@%0d", name, k), level, (ev != 0 && k >= ev) ? ~lv0 : lv0);
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("rst level", level, 1'b0);
        chk("rst press", press, 1'b0);
        chk("rst release", release_p, 1'b0);
        chk("rst long", long_p, 1'b0);
        rst = 1'b0;
        watch("idle", 4, 0, 0, 0, 1'b0);
        btn = 1'b0;
        watch("press", 14, 11, 0, 0, 1'b0);
        btn = 1'b1;
        watch("release", 14, 0, 11, 0, 1'b1);
        btn = 1'b0;
        watch("glitch_lo", 7, 0, 0, 0, 1'b0);
        btn = 1'b1;
        watch("glitch_hi", 12, 0, 0, 0, 1'b0);
        btn = 1'b0;
        watch("bounce_a", 5, 0, 0, 0, 1'b0);
        btn = 1'b1;
        watch("bounce_b", 1, 0, 0, 0, 1'b0);
        btn = 1'b0;
        watch("bounce_press", 14, 11, 0, 0, 1'b0);
        btn = 1'b1;
        watch("rel_bounce_a", 3, 0, 0, 0, 1'b1);
        btn = 1'b0;
        watch("rel_bounce_b", 8, 0, 0, 0, 1'b1);
        btn = 1'b1;
        watch("release2", 14, 0, 11, 0, 1'b1);
        btn = 1'b0;
        watch("press2", 14, 11, 0, 0, 1'b0);
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("held_rst level@%0d", k), level, 1'b0);
            chk($sformatf("held_rst press@%0d", k), press, 1'b0);
            chk($sformatf("held_rst release@%0d", k), release_p, 1'b0);
        end
        rst = 1'b0;
        watch("requal", 14, 11, 0, 0, 1'b0);
        btn = 1'b1;
        watch("release3", 14, 0, 11, 0, 1'b1);
        btn = 1'b0;
        watch("pre_drop", 10, 0, 0, 0, 1'b0);
        rst = 1'b1;
        tick();
        chk("drop press", press, 1'b0);
        chk("drop level", level, 1'b0);
        rst = 1'b0;
        watch("after_drop", 14, 11, 0, 0, 1'b0);
        btn = 1'b1;
        watch("release4", 14, 0, 11, 0, 1'b1);
        btn = 1'b0;
        watch("long", 80, 11, 0, LE, 1'b0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
